ddr_read_burst_gen: RTL and testbench

- Upstream feeder for the DDR AXI read-assist stage.
- Accepts one linear read command (start address plus byte count) and splits it into AXI INCR bursts.
- Presents each burst as a one-cycle read_request pulse with axi_rid/axi_raddr/axi_len, obeying the assist's axi_ready.
- Tracks bursts in flight via the assist's ddr_vid/ddr_isLast return path and pulses done when the whole command has returned.

---
 rtl/ddr_read_burst_gen.sv | 145 ++++++++++++++
 tb/tb_ddr_read_burst_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_read_burst_gen.sv
// Splits one linear read command into AXI INCR bursts for the DDR read-assist stage,
// limits bursts in flight and pulses done once every burst has returned.
// Optional 4 KB boundary guard: define DDR_RD_4K_GUARD_EN.
module ddr_read_burst_gen #(
    parameter int              ADDR_W             = 32,
    parameter int              ID_W               = 4,
    parameter int              LEN_W              = 8,
    parameter logic [ID_W-1:0] RID                = ID_W'(1),
    parameter int              C_M_AXI_DATA_WIDTH = 256,
    parameter int              MAX_BURST_BEATS    = 16,
    parameter int              MAX_OUTSTANDING    = 4
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_bytes,
    output logic              busy,
    output logic              done,
    input  logic              axi_ready,
    output logic              read_request,
    output logic [ID_W-1:0]   axi_rid,
    output logic [ADDR_W-1:0] axi_raddr,
    output logic [LEN_W-1:0]  axi_len,
    input  logic [ID_W-1:0]   ddr_vid,
    input  logic              ddr_isLast
);

    localparam int          BB          = C_M_AXI_DATA_WIDTH / 8;
    localparam int          BB_LOG      = $clog2(BB);
    localparam logic [31:0] MAX_BEATS_C = 32'(MAX_BURST_BEATS);
    localparam logic [3:0]  MAX_OUT_C   = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [31:0]       r_rem_beats;
    logic [3:0]        r_outstanding;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_done;

    logic [32:0]       w_bytes_up;
    logic [31:0]       w_cmd_beats;
    logic [31:0]       w_guard_beats;
    logic [31:0]       w_beats_lim;
    logic [31:0]       w_beats;
    logic [ADDR_W-1:0] w_addr_step;
    logic [LEN_W-1:0]  w_axi_len;
    logic              w_issue;
    logic              w_cpl;
    logic              w_cpl_eff;
    logic [3:0]        w_out_next;

    // 33-bit sum so a byte count near 2^32 still rounds up without overflow
    assign w_bytes_up  = {1'b0, cmd_bytes} + 33'(BB - 1);
    assign w_cmd_beats = 32'(w_bytes_up >> BB_LOG);

`ifdef DDR_RD_4K_GUARD_EN
    assign w_guard_beats = (32'd4096 - {20'd0, r_cur_addr[11:0]}) >> BB_LOG;
`else
    assign w_guard_beats = MAX_BEATS_C;
`endif

    assign w_beats_lim = (r_rem_beats < MAX_BEATS_C) ? r_rem_beats : MAX_BEATS_C;
    assign w_beats     = (w_guard_beats < w_beats_lim) ? w_guard_beats : w_beats_lim;
    assign w_addr_step = ADDR_W'(w_beats << BB_LOG);
    assign w_axi_len   = (w_beats == 32'd0) ? {LEN_W{1'b0}} : LEN_W'(w_beats - 32'd1);

    assign w_issue    = (r_state == ST_ISSUE) && axi_ready && (r_outstanding < MAX_OUT_C);
    assign w_cpl      = (ddr_vid == RID) && ddr_isLast;
    // completions with nothing in flight (e.g. stale beats after reset) are dropped
    assign w_cpl_eff  = w_cpl && (r_outstanding != 4'd0);
    assign w_out_next = r_outstanding + {3'd0, w_issue} - {3'd0, w_cpl_eff};

    assign cmd_ready    = r_cmd_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign read_request = w_issue;
    assign axi_rid      = RID;
    assign axi_raddr    = r_cur_addr;
    assign axi_len      = w_axi_len;

    // command sequencing, burst bookkeeping and in-flight tracking
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ST_IDLE;
            r_cur_addr    <= {ADDR_W{1'b0}};
            r_rem_beats   <= 32'd0;
            r_outstanding <= 4'd0;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            r_done        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cur_addr  <= cmd_addr;
                        r_rem_beats <= w_cmd_beats;
                        if (w_cmd_beats == 32'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= ST_ISSUE;
                            r_cmd_ready <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        r_cur_addr  <= r_cur_addr + w_addr_step;
                        r_rem_beats <= r_rem_beats - w_beats;
                        r_state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_state <= (r_rem_beats != 32'd0) ? ST_ISSUE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_out_next == 4'd0) begin
                        r_done      <= 1'b1;
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_read_burst_gen.sv
// Self-checking bench for ddr_read_burst_gen: directed scenarios plus random commands,
// checked every cycle against a burst-list / in-flight-count reference model.
module tb_ddr_read_burst_gen;

    localparam int         BB   = 32;
    localparam int         MAXB = 16;
    localparam int         MAXO = 4;
    localparam logic [3:0] RID  = 4'd1;

    logic        clock;
    logic        resetN;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_bytes;
    logic        busy;
    logic        done;
    logic        axi_ready;
    logic        read_request;
    logic [3:0]  axi_rid;
    logic [31:0] axi_raddr;
    logic [7:0]  axi_len;
    logic [3:0]  ddr_vid;
    logic        ddr_isLast;

    ddr_read_burst_gen dut (
        .clock        (clock),
        .resetN       (resetN),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_bytes    (cmd_bytes),
        .busy         (busy),
        .done         (done),
        .axi_ready    (axi_ready),
        .read_request (read_request),
        .axi_rid      (axi_rid),
        .axi_raddr    (axi_raddr),
        .axi_len      (axi_len),
        .ddr_vid      (ddr_vid),
        .ddr_isLast   (ddr_isLast)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model state
    logic [31:0] q_addr[$];
    logic [7:0]  q_len[$];
    int          m_pend;
    logic        m_busy;
    logic        m_done_due;
    int          m_next_ok;
    int          m_last_req;
    int          cyc;
    int          n_req;
    int          n_pass;
    int          n_checks;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic model_reset();
        q_addr.delete();
        q_len.delete();
        m_pend     = 0;
        m_busy     = 1'b0;
        m_done_due = 1'b0;
        m_next_ok  = 0;
        m_last_req = -100;
    endtask

    // list of bursts a command must produce, in order
    task automatic build(input logic [31:0] addr, input logic [31:0] bytes);
        longint      left;
        longint      b;
        logic [31:0] a;
`ifdef DDR_RD_4K_GUARD_EN
        longint      g;
`endif
        q_addr.delete();
        q_len.delete();
        left = (longint'(bytes) + BB - 1) / BB;
        a    = addr;
        while (left > 0) begin
            b = (left < MAXB) ? left : MAXB;
`ifdef DDR_RD_4K_GUARD_EN
            g = (4096 - longint'(a % 4096)) / BB;
            if (g < b) b = g;
`endif
            q_addr.push_back(a);
            q_len.push_back(8'(b - 1));
            a    = a + 32'(b * BB);
            left = left - b;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_read_request"}, read_request, 1'b0);
        chk({tag, "_axi_raddr"}, axi_raddr, 32'd0);
        chk({tag, "_axi_len"}, axi_len, 8'd0);
        chk({tag, "_axi_rid"}, axi_rid, RID);
    endtask

    // one clock cycle: drive inputs after the edge, check outputs at the falling edge
    task automatic step(input logic rdy, input logic [3:0] vid, input logic last,
                        input logic cv, input logic [31:0] ca, input logic [31:0] cb);
        logic exp_req;
        logic cpl_eff;
        @(posedge clock);
        #1;
        axi_ready  = rdy;
        ddr_vid    = vid;
        ddr_isLast = last;
        cmd_valid  = cv;
        cmd_addr   = ca;
        cmd_bytes  = cb;
        @(negedge clock);
        cyc++;
        exp_req = m_busy && (q_addr.size() != 0) && rdy && (m_pend < MAXO) && (cyc >= m_next_ok);
        chk("cmd_ready", cmd_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("done", done, m_done_due);
        chk("read_request", read_request, exp_req);
        if (m_busy && (q_addr.size() != 0) && (cyc >= m_next_ok)) begin
            chk("axi_raddr", axi_raddr, q_addr[0]);
            chk("axi_len", axi_len, q_len[0]);
        end
        if (read_request) n_req++;
        cpl_eff = (vid == RID) && last && (m_pend > 0);
        if (exp_req) begin
            void'(q_addr.pop_front());
            void'(q_len.pop_front());
            m_pend++;
            m_last_req = cyc;
            m_next_ok  = cyc + 2;
        end
        if (cpl_eff) m_pend--;
        m_done_due = 1'b0;
        if (!m_busy && cv) begin
            build(ca, cb);
            if (q_addr.size() == 0) begin
                m_done_due = 1'b1;
            end else begin
                m_busy    = 1'b1;
                m_next_ok = cyc + 1;
            end
        end else if (m_busy && (q_addr.size() == 0) && (m_pend == 0) && (cyc >= m_last_req + 2)) begin
            m_done_due = 1'b1;
            m_busy     = 1'b0;
        end
    endtask

    task automatic start_cmd(input logic [31:0] addr, input logic [31:0] bytes);
        step(1'b1, 4'd0, 1'b0, 1'b1, addr, bytes);
    endtask

    // run the current command to completion with random ready / return traffic
    task automatic finish_cmd(input int rdy_pct, input int cpl_pct, input int budget);
        int         n;
        logic       rdy;
        logic       cpl;
        logic [3:0] vid;
        logic       last;
        n = 0;
        while ((m_busy || m_done_due) && (n < budget)) begin
            rdy = ($urandom_range(99) < rdy_pct);
            cpl = (m_pend > 0) && ($urandom_range(99) < cpl_pct);
            if (cpl) begin
                vid  = RID;
                last = 1'b1;
            end else if ($urandom_range(4) == 0) begin
                vid  = ($urandom_range(1) == 0) ? 4'd2 : RID;
                last = (vid != RID);
            end else begin
                vid  = 4'd0;
                last = 1'b0;
            end
            step(rdy, vid, last, m_busy && ($urandom_range(7) == 0), $urandom, $urandom);
            n++;
        end
        chk("cmd_finished", m_busy || m_done_due, 1'b0);
    endtask

    initial begin
        int          base;
        logic [31:0] ra;
        logic [31:0] rb;
        n_pass     = 0;
        n_checks   = 0;
        n_req      = 0;
        cyc        = 0;
        model_reset();
        resetN     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = 32'd0;
        cmd_bytes  = 32'd0;
        axi_ready  = 1'b0;
        ddr_vid    = 4'd0;
        ddr_isLast = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        resetN = 1'b1;
        repeat (2) step(1'b1, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // long command, prompt returns: 16 x len 15, two cycles apart
        base = n_req;
        start_cmd(32'h0, 32'd8192);
        finish_cmd(100, 100, 200);
        chk("long_req_count", n_req - base, 16);

        // 4 KB boundary case
        base = n_req;
        start_cmd(32'hF80, 32'd256);
        finish_cmd(100, 100, 50);
`ifdef DDR_RD_4K_GUARD_EN
        chk("guard_req_count", n_req - base, 2);
`else
        chk("guard_req_count", n_req - base, 1);
`endif

        // zero bytes: done only, no request
        base = n_req;
        start_cmd(32'h40, 32'd0);
        finish_cmd(100, 100, 10);
        chk("zero_req_count", n_req - base, 0);

        // 40 bytes rounds up to two beats
        base = n_req;
        start_cmd(32'h2000, 32'd40);
        finish_cmd(100, 100, 20);
        chk("b40_req_count", n_req - base, 1);

        // in-flight limit: 8 bursts, no returns
        base = n_req;
        start_cmd(32'h0, 32'd4096);
        repeat (30) step(1'b1, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("limit_req_count", n_req - base, 4);
        repeat (3) step(1'b1, 4'd2, 1'b1, 1'b0, 32'd0, 32'd0);
        repeat (3) step(1'b1, RID, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("limit_foreign", n_req - base, 4);
        step(1'b1, RID, 1'b1, 1'b0, 32'd0, 32'd0);
        repeat (3) step(1'b1, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("limit_release", n_req - base, 5);
        finish_cmd(100, 100, 300);
        chk("limit_total", n_req - base, 8);

        // stall: axi_ready low for 10 cycles while a burst is pending
        base = n_req;
        start_cmd(32'h100, 32'd1536);
        for (int i = 0; (i < 5) && (n_req - base < 1); i++)
            step(1'b1, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (10) step(1'b0, (m_pend > 0) ? RID : 4'd0, m_pend > 0, 1'b0, 32'd0, 32'd0);
        chk("stall_held", n_req - base, 1);
        step(1'b1, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("stall_release", n_req - base, 2);
        finish_cmd(100, 100, 100);
        chk("stall_total", n_req - base, 3);

        // asynchronous reset after 3 of 8 bursts
        base = n_req;
        start_cmd(32'h4000, 32'd4096);
        for (int i = 0; (i < 40) && (n_req - base < 3); i++)
            step(1'b1, (m_pend > 0) ? RID : 4'd0, m_pend > 0, 1'b0, 32'd0, 32'd0);
        chk("rst_pre_count", n_req - base, 3);
        #2;
        resetN = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        repeat (2) step(1'b1, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        resetN = 1'b1;
        base = n_req;
        repeat (4) step(1'b1, RID, 1'b1, 1'b0, 32'd0, 32'd0);
        chk("rst_stale_no_req", n_req - base, 0);
        start_cmd(32'h80, 32'd40);
        finish_cmd(100, 100, 20);
        chk("rst_after_count", n_req - base, 1);

        // random commands
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(2))
                0:       ra = $urandom & 32'hFFFF_FFE0;
                1:       ra = 32'hFFFF_FE00 + 32'($urandom_range(15)) * 32'd32;
                default: ra = 32'($urandom_range(1, 7)) * 32'd4096 - 32'($urandom_range(1, 20)) * 32'd32;
            endcase
            rb = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : 32'($urandom_range(3000));
            start_cmd(ra, rb);
            finish_cmd($urandom_range(50, 100), $urandom_range(20, 90), 2000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
